// File: rtl/traffic_lane.sv
// One road row of WIDTH car cells, rotated once per period+1 game ticks, with a buffered pattern load.
// Optional macro TRAFFIC_LANE_SPAWN_EN: an LFSR feeds the cell entering on each rotating step.
module traffic_lane #(
  parameter int unsigned               WIDTH         = 16,
  parameter int unsigned               PERIOD_W      = 4,
  parameter logic [WIDTH-1:0]          RESET_PATTERN = WIDTH'(16'h1318)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  input  logic                dir,
  input  logic                load_valid,
  input  logic [WIDTH-1:0]    load_pattern,
  output logic                load_ready,
  input  logic [WIDTH-1:0]    player_mask,
  output logic [WIDTH-1:0]    lane,
  output logic                step,
  output logic                hit,
  output logic                state_dbg
);

  // Handshake: a pattern transfers on any clock edge where load_valid && load_ready
  // are both high; load_valid may rise at any time and the pattern is held in buf_q
  // until the next step event installs it.
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} load_state_e;

  load_state_e         state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    lane_q, lane_d;
  logic [WIDTH-1:0]    buf_q, buf_d;
  logic                step_q, hit_q;
  logic                step_evt;
  logic                accept;
  logic                enter_bit;

  assign step_evt   = tick && run && (cnt_q >= period);
  assign load_ready = (state_q == ST_EMPTY) && !reset;
  assign accept     = load_valid && load_ready;

`ifdef TRAFFIC_LANE_SPAWN_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Only rotating steps consume randomness; load steps leave the sequence untouched.
  always_comb begin
    lfsr_d = lfsr_q;
    if (step_evt && state_q == ST_EMPTY) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign enter_bit = lfsr_q[0] & lfsr_q[1];
`else
  assign enter_bit = dir ? lane_q[WIDTH-1] : lane_q[0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    buf_d   = buf_q;

    if (tick && run) begin
      cnt_d = step_evt ? '0 : cnt_q + PERIOD_W'(1);
    end

    // A pending pattern is tested before capture, so a same-cycle accept waits one step.
    if (step_evt) begin
      if (state_q == ST_FULL) lane_d = buf_q;
      else if (dir)           lane_d = {lane_q[WIDTH-2:0], enter_bit};
      else                    lane_d = {enter_bit, lane_q[WIDTH-1:1]};
    end

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          buf_d   = load_pattern;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (step_evt) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
      lane_q  <= RESET_PATTERN;
      buf_q   <= '0;
      step_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      buf_q   <= buf_d;
      step_q  <= step_evt;
      hit_q   <= |(lane_q & player_mask);
    end
  end

  assign lane      = lane_q;
  assign step      = step_q;
  assign hit       = hit_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_traffic_lane.sv
// Self-checking bench for traffic_lane at default parameters, spawn macro undefined.
module tb_traffic_lane;

  localparam int W  = 16;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic          run;
  logic [PW-1:0] period;
  logic          dir;
  logic          load_valid;
  logic [W-1:0]  load_pattern;
  logic          load_ready;
  logic [W-1:0]  player_mask;
  logic [W-1:0]  lane;
  logic          step;
  logic          hit;
  logic          state_dbg;

  logic [W-1:0]  exp_q[$];
  int            pass_cnt  = 0;
  int            total_cnt = 0;

  traffic_lane dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .run          (run),
    .period       (period),
    .dir          (dir),
    .load_valid   (load_valid),
    .load_pattern (load_pattern),
    .load_ready   (load_ready),
    .player_mask  (player_mask),
    .lane         (lane),
    .step         (step),
    .hit          (hit),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic idle_inputs();
    tick = 0; run = 1; period = '0; dir = 0;
    load_valid = 0; load_pattern = '0; player_mask = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cyc(); cyc();
    reset = 0;
    cyc();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    cyc(); cyc();
    total_cnt++; if (lane !== 16'h1318) $display("FAIL rst_lane: got %h expected 1318", lane); else pass_cnt++;
    total_cnt++; if (step !== 1'b0) $display("FAIL rst_step: got %b expected 0", step); else pass_cnt++;
    total_cnt++; if (hit !== 1'b0) $display("FAIL rst_hit: got %b expected 0", hit); else pass_cnt++;
    total_cnt++; if (load_ready !== 1'b0) $display("FAIL rst_ready_in_reset: got %b expected 0", load_ready); else pass_cnt++;
    reset = 0;
    cyc();
    total_cnt++; if (load_ready !== 1'b1) $display("FAIL rst_ready_after: got %b expected 1", load_ready); else pass_cnt++;
  endtask

  task automatic test_rotate_right();
    logic [W-1:0] e;
    run = 1; period = 0; dir = 0; tick = 1;
    exp_q.push_back(16'h098C); exp_q.push_back(16'h04C6); exp_q.push_back(16'h0263);
    for (int i = 0; i < 3; i++) begin
      cyc();
      e = pop_exp();
      total_cnt++; if (lane !== e) $display("FAIL rot_lane%0d: got %h expected %h", i, lane, e); else pass_cnt++;
      total_cnt++; if (step !== 1'b1) $display("FAIL rot_step%0d: got %b expected 1", i, step); else pass_cnt++;
    end
    tick = 0;
    cyc();
    total_cnt++; if (step !== 1'b0) $display("FAIL rot_step_idle: got %b expected 0", step); else pass_cnt++;
  endtask

  task automatic test_period_dir();
    logic [W-1:0] e;
    do_reset();
    dir = 1; period = 2; tick = 1;
    exp_q.push_back(16'h2630);
    for (int i = 0; i < 2; i++) begin
      cyc();
      total_cnt++; if (lane !== 16'h1318) $display("FAIL per_hold%0d: got %h expected 1318", i, lane); else pass_cnt++;
      total_cnt++; if (step !== 1'b0) $display("FAIL per_nostep%0d: got %b expected 0", i, step); else pass_cnt++;
    end
    cyc();
    e = pop_exp();
    total_cnt++; if (lane !== e) $display("FAIL per_lane: got %h expected %h", lane, e); else pass_cnt++;
    total_cnt++; if (step !== 1'b1) $display("FAIL per_step: got %b expected 1", step); else pass_cnt++;
    tick = 0;
    cyc();
    total_cnt++; if (step !== 1'b0) $display("FAIL per_step_pulse: got %b expected 0", step); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [W-1:0] e;
    period = 0; tick = 0; dir = 0;
    load_valid = 1; load_pattern = 16'h0001;
    cyc();
    load_valid = 0;
    total_cnt++; if (load_ready !== 1'b0) $display("FAIL wrap_ready: got %b expected 0", load_ready); else pass_cnt++;
    total_cnt++; if (state_dbg !== 1'b1) $display("FAIL wrap_state: got %b expected 1", state_dbg); else pass_cnt++;
    exp_q.push_back(16'h0001); exp_q.push_back(16'h8000); exp_q.push_back(16'h0001);
    for (int i = 0; i < 3; i++) begin
      dir = (i == 2);
      tick = 1;
      cyc();
      e = pop_exp();
      total_cnt++; if (lane !== e) $display("FAIL wrap_lane%0d: got %h expected %h", i, lane, e); else pass_cnt++;
    end
    tick = 0;
  endtask

  task automatic test_handshake();
    logic [W-1:0] e;
    do_reset();
    period = 3; dir = 0; tick = 0;
    load_valid = 1; load_pattern = 16'h00F0;
    cyc();
    total_cnt++; if (load_ready !== 1'b0) $display("FAIL hs_ready_low: got %b expected 0", load_ready); else pass_cnt++;
    load_pattern = 16'hFFFF;
    exp_q.push_back(16'h00F0); exp_q.push_back(16'h0078);
    tick = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total_cnt++; if (lane !== 16'h1318) $display("FAIL hs_hold%0d: got %h expected 1318", i, lane); else pass_cnt++;
      total_cnt++; if (load_ready !== 1'b0) $display("FAIL hs_busy%0d: got %b expected 0", i, load_ready); else pass_cnt++;
    end
    cyc();
    e = pop_exp();
    total_cnt++; if (lane !== e) $display("FAIL hs_load_lane: got %h expected %h", lane, e); else pass_cnt++;
    total_cnt++; if (step !== 1'b1) $display("FAIL hs_load_step: got %b expected 1", step); else pass_cnt++;
    total_cnt++; if (load_ready !== 1'b1) $display("FAIL hs_ready_back: got %b expected 1", load_ready); else pass_cnt++;
    load_valid = 0;
    for (int i = 0; i < 4; i++) cyc();
    e = pop_exp();
    total_cnt++; if (lane !== e) $display("FAIL hs_second_dropped: got %h expected %h", lane, e); else pass_cnt++;
    tick = 0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    period = 0; dir = 0; tick = 1;
    load_valid = 1; load_pattern = 16'h0F00;
    exp_q.push_back(16'h003C); exp_q.push_back(16'h0F00); exp_q.push_back(16'h0780);
    cyc();
    load_valid = 0;
    e = pop_exp();
    total_cnt++; if (lane !== e) $display("FAIL b2b_same_cycle: got %h expected %h", lane, e); else pass_cnt++;
    total_cnt++; if (load_ready !== 1'b0) $display("FAIL b2b_ready: got %b expected 0", load_ready); else pass_cnt++;
    cyc();
    e = pop_exp();
    total_cnt++; if (lane !== e) $display("FAIL b2b_applied: got %h expected %h", lane, e); else pass_cnt++;
    cyc();
    e = pop_exp();
    total_cnt++; if (lane !== e) $display("FAIL b2b_rotate: got %h expected %h", lane, e); else pass_cnt++;
    tick = 0;
  endtask

  task automatic test_freeze_hit();
    do_reset();
    period = 3; run = 1; tick = 1;
    cyc(); cyc();
    run = 0;
    for (int i = 0; i < 6; i++) begin
      tick = i[0];
      cyc();
      total_cnt++; if (lane !== 16'h1318 || step !== 1'b0)
        $display("FAIL frz%0d: got lane %h step %b expected 1318/0", i, lane, step); else pass_cnt++;
    end
    run = 1; tick = 1;
    cyc();
    total_cnt++; if (step !== 1'b0) $display("FAIL frz_cnt_held: got %b expected 0", step); else pass_cnt++;
    cyc();
    total_cnt++; if (lane !== 16'h098C) $display("FAIL frz_resume: got %h expected 098C", lane); else pass_cnt++;
    tick = 0; period = 0;
    load_valid = 1; load_pattern = 16'h0100;
    cyc();
    load_valid = 0; tick = 1;
    cyc();
    tick = 0;
    total_cnt++; if (lane !== 16'h0100) $display("FAIL hit_setup: got %h expected 0100", lane); else pass_cnt++;
    player_mask = 16'h0100;
    total_cnt++; if (hit !== 1'b0) $display("FAIL hit_lag: got %b expected 0", hit); else pass_cnt++;
    cyc();
    total_cnt++; if (hit !== 1'b1) $display("FAIL hit_on: got %b expected 1", hit); else pass_cnt++;
    player_mask = 16'h0200;
    cyc();
    total_cnt++; if (hit !== 1'b0) $display("FAIL hit_off: got %b expected 0", hit); else pass_cnt++;
    run = 0; player_mask = 16'h0100;
    cyc();
    total_cnt++; if (hit !== 1'b1) $display("FAIL hit_frozen: got %b expected 1", hit); else pass_cnt++;
    run = 1; player_mask = '0;
  endtask

  task automatic test_reset_full();
    logic [W-1:0] e;
    do_reset();
    tick = 0; load_valid = 1; load_pattern = 16'hAAAA;
    cyc();
    total_cnt++; if (load_ready !== 1'b0) $display("FAIL rf_full: got %b expected 0", load_ready); else pass_cnt++;
    reset = 1; load_pattern = 16'h5555;
    cyc();
    total_cnt++; if (lane !== 16'h1318) $display("FAIL rf_lane: got %h expected 1318", lane); else pass_cnt++;
    total_cnt++; if (load_ready !== 1'b0) $display("FAIL rf_ready_rst: got %b expected 0", load_ready); else pass_cnt++;
    cyc();
    total_cnt++; if (load_ready !== 1'b0) $display("FAIL rf_ready_rst2: got %b expected 0", load_ready); else pass_cnt++;
    reset = 0; load_valid = 0;
    cyc();
    total_cnt++; if (load_ready !== 1'b1) $display("FAIL rf_ready_rel: got %b expected 1", load_ready); else pass_cnt++;
    exp_q.push_back(16'h098C);
    period = 0; dir = 0; run = 1; tick = 1;
    cyc();
    tick = 0;
    e = pop_exp();
    total_cnt++; if (lane !== e) $display("FAIL rf_discard: got %h expected %h", lane, e); else pass_cnt++;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_rotate_right();
    test_period_dir();
    test_wrap();
    test_handshake();
    test_back_to_back();
    test_freeze_hit();
    test_reset_full();
    total_cnt++; if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d expected 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
